// File: rtl/serdes_pkg.sv
// Shared serializer/deserializer definitions: FSM state encoding reused by both ends.
package serdes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serdes_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Datapath shift register for the serializer: parallel load, shift right by one, or hold.
module piso_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Load wins over shift; the vacated MSB is filled with zero.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {1'b0, shreg_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts an NBITS word and streams it LSB first
// with first/last framing; all outputs derive from registered state only.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last
);

  localparam int unsigned CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  serdes_state_e    state_q;
  serdes_state_e    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             shift;
  logic [NBITS-1:0] shreg;

  piso_shift_reg #(
    .W (NBITS)
  ) u_shift_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (in_msg),
    .q_o     (shreg)
  );

  // Next-state, counter and handshake outputs; outputs depend on state_q/cnt_q/shreg only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    out_bit   = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          state_d = SEND;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        out_val   = 1'b1;
        out_bit   = shreg[0];
        out_first = (cnt_q == '0);
        out_last  = (cnt_q == CNT_LAST);
        if (out_rdy) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus a randomized run
// against a queue-of-bits reference model.
module tb_piso_serializer;

  localparam int unsigned NBITS = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg;
  logic             out_val;
  logic             out_rdy;
  logic             out_bit;
  logic             out_first;
  logic             out_last;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.NBITS(NBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bit i of a word, LSB first.
  function automatic logic word_bit(input logic [NBITS-1:0] w, input int i);
    return logic'((w >> i) & 1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({in_rdy, out_val, out_bit, out_first, out_last} !== 5'b10000) begin
        errors++;
        $display("FAIL reset[%0d]: rdy/val/bit/first/last got %b want 10000", k,
                 {in_rdy, out_val, out_bit, out_first, out_last});
      end
      tick();
    end
  endtask

  // Accept a word (caller ensures in_rdy=1), then check its NBITS beats with out_rdy=1.
  task automatic test_basic(input logic [NBITS-1:0] w, input string name);
    in_val = 1'b1; in_msg = w; out_rdy = 1'b1;
    tick();
    in_val = 1'b0; in_msg = ~w;
    for (int i = 0; i < NBITS; i++) begin
      checks++;
      if ({out_val, in_rdy, out_bit, out_first, out_last} !==
          {1'b1, 1'b0, word_bit(w, i), i == 0, i == NBITS - 1}) begin
        errors++;
        $display("FAIL %s beat %0d: val/rdy/bit/first/last got %b want %b", name, i,
                 {out_val, in_rdy, out_bit, out_first, out_last},
                 {1'b1, 1'b0, word_bit(w, i), i == 0, i == NBITS - 1});
      end
      tick();
    end
    checks++;
    if ({in_rdy, out_val, out_first, out_last} !== 4'b1000) begin
      errors++;
      $display("FAIL %s end: rdy/val/first/last got %b want 1000", name,
               {in_rdy, out_val, out_first, out_last});
    end
  endtask

  task automatic test_backpressure();
    logic [NBITS-1:0] w = 8'hA5;
    in_val = 1'b1; in_msg = w; out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      if (i == 2) begin
        out_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if ({out_val, out_bit, out_first, out_last} !== 4'b1100) begin
            errors++;
            $display("FAIL bp stall %0d: val/bit/first/last got %b want 1100", s,
                     {out_val, out_bit, out_first, out_last});
          end
        end
        out_rdy = 1'b1;
      end
      checks++;
      if ({out_val, out_bit, out_first, out_last} !==
          {1'b1, word_bit(w, i), i == 0, i == NBITS - 1}) begin
        errors++;
        $display("FAIL bp beat %0d: val/bit/first/last got %b want %b", i,
                 {out_val, out_bit, out_first, out_last},
                 {1'b1, word_bit(w, i), i == 0, i == NBITS - 1});
      end
      tick();
    end
    checks++;
    if ({in_rdy, out_val} !== 2'b10) begin
      errors++;
      $display("FAIL bp end: rdy/val got %b want 10", {in_rdy, out_val});
    end
  endtask

  task automatic test_busy_ignored();
    logic [NBITS-1:0] w0 = 8'h0F;
    logic [NBITS-1:0] w1 = 8'hFF;
    in_val = 1'b1; in_msg = w0; out_rdy = 1'b1;
    tick();
    in_msg = w1;  // in_val stays high while busy
    for (int i = 0; i < NBITS; i++) begin
      checks++;
      if ({out_val, in_rdy, out_bit} !== {1'b1, 1'b0, word_bit(w0, i)}) begin
        errors++;
        $display("FAIL busy beat %0d: val/rdy/bit got %b want %b", i,
                 {out_val, in_rdy, out_bit}, {1'b1, 1'b0, word_bit(w0, i)});
      end
      tick();
    end
    checks++;
    if ({in_rdy, out_val} !== 2'b10) begin
      errors++;
      $display("FAIL busy gap: rdy/val got %b want 10", {in_rdy, out_val});
    end
    tick();
    in_val = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      checks++;
      if ({out_val, out_bit, out_first} !== {1'b1, word_bit(w1, i), i == 0}) begin
        errors++;
        $display("FAIL busy 2nd beat %0d: val/bit/first got %b want %b", i,
                 {out_val, out_bit, out_first}, {1'b1, word_bit(w1, i), i == 0});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [NBITS-1:0] words [2] = '{8'h01, 8'h80};
    int idle_cycles = 0;
    in_val = 1'b1; in_msg = words[0]; out_rdy = 1'b1;
    tick();
    in_msg = words[1];
    for (int wi = 0; wi < 2; wi++) begin
      for (int i = 0; i < NBITS; i++) begin
        checks++;
        if ({out_val, out_bit, out_first, out_last} !==
            {1'b1, word_bit(words[wi], i), i == 0, i == NBITS - 1}) begin
          errors++;
          $display("FAIL b2b w%0d beat %0d: val/bit/first/last got %b want %b", wi, i,
                   {out_val, out_bit, out_first, out_last},
                   {1'b1, word_bit(words[wi], i), i == 0, i == NBITS - 1});
        end
        tick();
      end
      if (wi == 0) begin
        while (!out_val && idle_cycles < 4) begin
          idle_cycles++;
          tick();
        end
        in_val = 1'b0;
        checks++;
        if (idle_cycles != 1) begin
          errors++;
          $display("FAIL b2b gap: idle cycles got %0d want 1", idle_cycles);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [NBITS-1:0] w = 8'hFF;
    in_val = 1'b1; in_msg = w; out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    for (int i = 0; i <= 4; i++) tick();
    checks++;
    if ({out_val, out_bit} !== 2'b11) begin
      errors++;
      $display("FAIL midrst pre: val/bit got %b want 11", {out_val, out_bit});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({out_val, in_rdy, out_first, out_last} !== 4'b0100) begin
      errors++;
      $display("FAIL midrst post: val/rdy/first/last got %b want 0100",
               {out_val, in_rdy, out_first, out_last});
    end
    test_basic(8'h00, "midrst_00");
  endtask

  // Randomized traffic vs. a queue model: a word becomes NBITS queued bits; in_rdy
  // is expected exactly when nothing is queued.
  task automatic test_random();
    logic q[$];
    int   beat = 0;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (in_rdy !== (q.size() == 0) || out_val !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand c%0d: rdy/val got %b%b want %b%b", c, in_rdy, out_val,
                 q.size() == 0, q.size() != 0);
      end else if (q.size() != 0) begin
        checks++;
        if ({out_bit, out_first, out_last} !== {q[0], beat == 0, q.size() == 1}) begin
          errors++;
          $display("FAIL rand c%0d: bit/first/last got %b want %b", c,
                   {out_bit, out_first, out_last}, {q[0], beat == 0, q.size() == 1});
        end
      end
      in_val  = logic'($urandom_range(0, 1));
      in_msg  = NBITS'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      if (q.size() != 0) begin
        if (out_rdy) begin
          void'(q.pop_front());
          beat = (q.size() == 0) ? 0 : beat + 1;
        end
      end else if (in_val) begin
        for (int i = 0; i < NBITS; i++) q.push_back(word_bit(in_msg, i));
        beat = 0;
      end
      tick();
    end
    in_val = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic(8'hB4, "basic_B4");
    test_backpressure();
    test_busy_ignored();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
